// File: rtl/program_loader_pkg.sv
// program_loader_pkg: loader state encoding, RAM depth and default core-reset pulse length
package program_loader_pkg;
    localparam int LD_WORDS      = 16;
    localparam int LD_RST_CYCLES = 2;
    typedef enum logic [2:0] {RST_HOLD, IDLE, PRE_RST, LOAD, POST_RST} ld_state_e;
endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: synchronous FIFO buffering host entries
//   clk, resetn      clock and async active-low reset
//   clr_i            synchronous flush
//   push_i, din_i    write an entry (ignored when full)
//   pop_i            drop the head entry (ignored when empty)
//   dout_o           head entry, valid while !empty_o
//   full_o, empty_o  occupancy flags
module loader_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout_o  = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clr_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + ONE;
            if (pop_i && !empty_o) rd_q <= rd_q + ONE;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: buffers a host byte stream and feeds it into the core's programming sequence
//   clk, resetn                   clock and async active-low reset
//   prog_start                    begin a load (honoured only in IDLE)
//   host_valid/data/last, ready   host byte handshake
//   read_ui_in, done_load         control block slot pulses (capture, RAM write)
//   programming, prog_data        drive the control block and memory data path
//   core_rst_n                    active-low core reset
//   load_busy, load_done, prog_err, words_loaded   status
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WORDS      = LD_WORDS,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_CYCLES = LD_RST_CYCLES
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       prog_start,
    input  logic       host_valid,
    input  logic [7:0] host_data,
    input  logic       host_last,
    output logic       host_ready,
    input  logic       read_ui_in,
    input  logic       done_load,
    output logic       programming,
    output logic [7:0] prog_data,
    output logic       core_rst_n,
    output logic       load_busy,
    output logic       load_done,
    output logic       prog_err,
    output logic [3:0] words_loaded
);
    localparam int CW = $clog2(RST_CYCLES) + 1;
    ld_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] words_q, words_d;
    logic done_q, done_d, err_q, err_d, last_seen_q, last_seen_d;
    logic fifo_clr, push, pop, full, empty, cnt_end;
    logic [8:0] head;
    loader_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .clr_i   (fifo_clr),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({host_last, host_data}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );
    assign host_ready   = !full && !last_seen_q && (state_q == PRE_RST || state_q == LOAD);
    assign push         = host_valid && host_ready;
    assign cnt_end      = cnt_q == CW'(RST_CYCLES - 1);
    assign programming  = state_q == PRE_RST || state_q == LOAD;
    assign core_rst_n   = state_q == IDLE || state_q == LOAD;
    assign load_busy    = state_q == PRE_RST || state_q == LOAD || state_q == POST_RST;
    assign prog_data    = (state_q == LOAD && !empty) ? head[7:0] : 8'h00;
    assign load_done    = done_q;
    assign prog_err     = err_q;
    assign words_loaded = words_q;
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        words_d     = words_q;
        done_d      = done_q;
        err_d       = err_q;
        last_seen_d = last_seen_q | (push & host_last);
        fifo_clr    = 1'b0;
        pop         = 1'b0;
        case (state_q)
            RST_HOLD: begin
                cnt_d   = cnt_end ? '0 : cnt_q + CW'(1);
                state_d = cnt_end ? IDLE : RST_HOLD;
            end
            IDLE: begin
                if (prog_start) begin
                    words_d     = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    last_seen_d = 1'b0;
                    fifo_clr    = 1'b1;
                    state_d     = PRE_RST;
                end
            end
            PRE_RST: begin
                cnt_d   = cnt_end ? '0 : cnt_q + CW'(1);
                state_d = cnt_end ? LOAD : PRE_RST;
            end
            LOAD: begin
                // An empty FIFO at capture still writes 0x00; the slot is counted but flagged.
                if (read_ui_in && empty) err_d = 1'b1;
                if (done_load) begin
                    pop     = !empty;
                    words_d = words_q + 4'd1;
                    if ((!empty && head[8]) || words_q == 4'(WORDS - 1)) state_d = POST_RST;
                end
            end
            POST_RST: begin
                fifo_clr = 1'b1;
                cnt_d    = cnt_end ? '0 : cnt_q + CW'(1);
                done_d   = done_q | cnt_end;
                state_d  = cnt_end ? IDLE : POST_RST;
            end
            default: state_d = RST_HOLD;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RST_HOLD;
            cnt_q       <= '0;
            words_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_seen_q <= last_seen_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized loads checked against a queue-based reference model
module tb_program_loader;
    localparam int FD = 4, RC = 2, NW = 16;
    localparam int P_HOLD = 0, P_IDLE = 1, P_PRE = 2, P_LD = 3, P_POST = 4;
    logic clk = 1'b0, resetn = 1'b0, prog_start = 1'b0, host_valid = 1'b0, host_last = 1'b0;
    logic read_ui_in = 1'b0, done_load = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic host_ready, programming, core_rst_n, load_busy, load_done, prog_err;
    logic [7:0] prog_data;
    logic [3:0] words_loaded;
    int n_cmp = 0, n_err = 0;
    int ph, cnt, words;
    bit done_m, err_m, lseen;
    logic [8:0] q[$], hq[$], src[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .resetn(resetn), .prog_start(prog_start),
        .host_valid(host_valid), .host_data(host_data), .host_last(host_last), .host_ready(host_ready),
        .read_ui_in(read_ui_in), .done_load(done_load), .programming(programming),
        .prog_data(prog_data), .core_rst_n(core_rst_n), .load_busy(load_busy),
        .load_done(load_done), .prog_err(prog_err), .words_loaded(words_loaded)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return (ph == P_PRE || ph == P_LD) && q.size() < FD && !lseen;
    endfunction

    task automatic m_reset();
        ph = P_HOLD; cnt = 0; words = 0; done_m = 0; err_m = 0; lseen = 0;
        q.delete();
    endtask

    task automatic m_edge();
        bit rdy, fin;
        logic [8:0] e;
        rdy = m_ready();
        fin = 0;
        case (ph)
            P_HOLD: begin cnt++; if (cnt == RC) begin ph = P_IDLE; cnt = 0; end end
            P_IDLE: if (prog_start) begin
                words = 0; done_m = 0; err_m = 0; lseen = 0; q.delete(); ph = P_PRE;
            end
            P_PRE: begin cnt++; if (cnt == RC) begin ph = P_LD; cnt = 0; end end
            P_LD: begin
                if (read_ui_in && q.size() == 0) err_m = 1;
                if (done_load) begin
                    if (q.size() > 0) begin e = q.pop_front(); fin = e[8]; end
                    words++;
                    if (words == NW) fin = 1;
                end
                if (fin) ph = P_POST;
            end
            P_POST: begin
                q.delete();
                cnt++;
                if (cnt == RC) begin done_m = 1; ph = P_IDLE; cnt = 0; end
            end
            default: ;
        endcase
        if (host_valid && rdy) begin
            q.push_back({host_last, host_data});
            if (host_last) lseen = 1;
            void'(hq.pop_front());
        end
    endtask

    task automatic check_all();
        chk("programming", 8'(programming), 8'(ph == P_PRE || ph == P_LD));
        chk("core_rst_n", 8'(core_rst_n), 8'(ph == P_IDLE || ph == P_LD));
        chk("host_ready", 8'(host_ready), 8'(m_ready()));
        chk("prog_data", prog_data, (ph == P_LD && q.size() > 0) ? q[0][7:0] : 8'h00);
        chk("load_busy", 8'(load_busy), 8'(ph >= P_PRE));
        chk("load_done", 8'(load_done), 8'(done_m));
        chk("prog_err", 8'(prog_err), 8'(err_m));
        chk("words_loaded", 8'(words_loaded), 8'(words % NW));
    endtask

    task automatic tick(input bit rd, input bit dl, input bit st);
        read_ui_in = rd; done_load = dl; prog_start = st;
        host_valid = hq.size() > 0;
        if (hq.size() > 0) {host_last, host_data} = hq[0];
        else {host_last, host_data} = 9'h000;
        @(posedge clk);
        if (resetn) m_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic slot(input bit add, input bit st);
        if (add && src.size() > 0) hq.push_back(src.pop_front());
        for (int c = 0; c < 7; c++) tick(c == 3, c == 4, st && c == 1);
    endtask

    task automatic fill(input int n, input bit mark);
        for (int i = 0; i < n; i++) src.push_back({mark && i == n - 1, 8'($urandom)});
    endtask

    task automatic run_load(input int exp_slots, input bit burst, input int skip, input int restart);
        int s;
        if (burst) while (src.size() > 0) hq.push_back(src.pop_front());
        tick(0, 0, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        s = 0;
        while (s < 20 && programming === 1'b1) begin
            slot(!burst && s != skip, s == restart);
            s++;
        end
        chk("slots", 8'(s), 8'(exp_slots));
        repeat (RC + 2) tick(0, 0, 0);
        hq.delete();
        src.delete();
    endtask

    initial begin
        m_reset();
        #1 check_all();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) tick(0, 0, 0);
        chk("idle_core_run", 8'(core_rst_n), 8'd1);

        for (int i = 0; i < 16; i++) src.push_back({1'b0, 8'(i)});
        run_load(16, 0, -1, -1);
        chk("full_done", 8'(load_done), 8'd1);
        chk("full_err", 8'(prog_err), 8'd0);
        chk("full_words", 8'(words_loaded), 8'd0);

        src.push_back(9'h04E); src.push_back(9'h05F); src.push_back(9'h100);
        run_load(3, 0, -1, -1);
        chk("short_words", 8'(words_loaded), 8'd3);

        fill(6, 1);
        run_load(6, 1, -1, 2);
        chk("burst_words", 8'(words_loaded), 8'd6);

        src.push_back(9'h011); src.push_back(9'h022); src.push_back(9'h033); src.push_back(9'h144);
        run_load(5, 0, 1, -1);
        chk("under_err", 8'(prog_err), 8'd1);
        chk("under_words", 8'(words_loaded), 8'd5);

        fill(8, 1);
        tick(0, 0, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        for (int s = 0; s < 5; s++) slot(1, 0);
        #2 resetn = 1'b0;
        m_reset();
        #1 check_all();
        chk("rst_words", 8'(words_loaded), 8'd0);
        repeat (2) tick(0, 0, 0);
        resetn = 1'b1;
        hq.delete();
        src.delete();
        tick(0, 0, 0);
        chk("rst_hold", 8'(core_rst_n), 8'd0);
        tick(0, 0, 0);
        chk("rst_idle", 8'(core_rst_n), 8'd1);

        for (int t = 0; t < 4; t++) begin
            int len, sk, ex;
            bit b;
            len = $urandom_range(1, 18);
            b = 1'($urandom_range(0, 1));
            sk = $urandom_range(0, len + 2);
            ex = len + ((!b && sk < len) ? 1 : 0);
            if (ex > NW) ex = NW;
            fill(len, len <= NW);
            run_load(ex, b, b ? -1 : sk, $urandom_range(0, 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
